mux_sel_arbiter: RTL

//  Round-robin arbiter that generates the select for the downstream 2:1 mux (mymux2) and routes

---
 rtl/mux_sel_arbiter_pkg.sv | 32 +++
 rtl/mux_sel_arbiter_burst_counter.sv | 37 +++
 rtl/mux_sel_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mux_sel_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mux_sel_arbiter_pkg
//   Shared definitions for the 2-source round-robin mux select arbiter:
//   FSM state encoding, mux select constants and the arbitration function.
// ----------------------------------------------------------------------------
package mux_sel_arbiter_pkg;

   // 2'd3 is never entered; the FSM sends it back to idle on the next edge
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } state_t;

   localparam logic SEL_IN0 = 1'b0;
   localparam logic SEL_IN1 = 1'b1;

   // Pick a grant from the current requests; prio breaks a tie
   function automatic state_t arb(input logic v0, input logic v1, input logic prio);
      state_t pick;
      if (v0 && v1)
         pick = prio ? ST_GRANT1 : ST_GRANT0;
      else if (v0)
         pick = ST_GRANT0;
      else if (v1)
         pick = ST_GRANT1;
      else
         pick = ST_IDLE;
      return pick;
   endfunction

endpackage

// File: rtl/mux_sel_arbiter_burst_counter.sv
// ----------------------------------------------------------------------------
// burst_counter
//   Counts accepted beats inside one grant and flags the final beat slot.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     clr          return count to 0 (takes precedence over inc)
//     inc          one beat accepted this cycle
//     count        beats accepted so far in the current grant
//     at_last      count has reached BURST_LEN-1
// ----------------------------------------------------------------------------
module burst_counter #(
   parameter int CNT_W     = 8,
   parameter int BURST_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             at_last
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_reg <= '0;
      else if (clr)
         count_reg <= '0;
      else if (inc)
         count_reg <= count_reg + CNT_W'(1);
   end

   assign count   = count_reg;
   assign at_last = (count_reg == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/mux_sel_arbiter.sv
// ----------------------------------------------------------------------------
// mux_sel_arbiter
//   Round-robin arbiter producing the registered select of a downstream 2:1
//   mux and routing valid/ready between two sources and one sink. A granted
//   source keeps the mux for up to BURST_LEN accepted beats, then the grant
//   moves to the other source if it is requesting (no bubble on handover).
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     in0_valid, in1_valid   source requests / beat present
//     out_ready              sink accepts the beat on the mux output
//     in0_ready, in1_ready   beat from that source accepted this cycle
//     out_valid              mux output carries a valid beat
//     sel                    mux select, 0 = in0, 1 = in1 (registered)
//     out_last               current beat is the final one of the burst
//     burst_cnt              beats accepted so far in the current grant
// ----------------------------------------------------------------------------
module mux_sel_arbiter
   import mux_sel_arbiter_pkg::*;
#(
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   input  logic             in1_valid,
   input  logic             out_ready,
   output logic             in0_ready,
   output logic             in1_ready,
   output logic             out_valid,
   output logic             sel,
   output logic             out_last,
   output logic [CNT_W-1:0] burst_cnt
);

   state_t state_reg, state_next;
   logic   prio_reg, prio_next;
   logic   sel_reg, sel_next;
   logic   release_grant;
   logic   xfer;
   logic   at_last;
   logic   cnt_clr;

   // Handshake routing is purely combinational on the current grant
   assign out_valid = ((state_reg == ST_GRANT0) && in0_valid) ||
                      ((state_reg == ST_GRANT1) && in1_valid);
   assign in0_ready = (state_reg == ST_GRANT0) && out_ready;
   assign in1_ready = (state_reg == ST_GRANT1) && out_ready;
   assign xfer      = out_valid && out_ready;
   assign out_last  = out_valid && at_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         prio_reg  <= 1'b0;
         sel_reg   <= SEL_IN0;
      end else begin
         state_reg <= state_next;
         prio_reg  <= prio_next;
         sel_reg   <= sel_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      prio_next     = prio_reg;
      release_grant = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            state_next = arb(in0_valid, in1_valid, prio_reg);
         end
         ST_GRANT0: begin
            // A missing valid forfeits the rest of the burst
            release_grant = (xfer && at_last) || !in0_valid;
            if (release_grant) begin
               prio_next  = 1'b1;
               state_next = arb(in0_valid, in1_valid, 1'b1);
            end
         end
         ST_GRANT1: begin
            release_grant = (xfer && at_last) || !in1_valid;
            if (release_grant) begin
               prio_next  = 1'b0;
               state_next = arb(in0_valid, in1_valid, 1'b0);
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // sel follows the next grant so it is already correct in the granted cycle;
   // in idle it holds its last value
   always_comb begin
      sel_next = sel_reg;
      if (state_next == ST_GRANT0)
         sel_next = SEL_IN0;
      else if (state_next == ST_GRANT1)
         sel_next = SEL_IN1;
   end

   // A release also covers re-granting the same source, which must restart at 0
   assign cnt_clr = release_grant || (state_next != state_reg);

   burst_counter #(
      .CNT_W     (CNT_W),
      .BURST_LEN (BURST_LEN)
   ) u_burst_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (cnt_clr),
      .inc     (xfer),
      .count   (burst_cnt),
      .at_last (at_last)
   );

   assign sel = sel_reg;

endmodule
